// File: rtl/counter_pkg.sv
// Shared types for the counter timer controller: FSM state encoding and
// mode constants.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } tmr_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Enable divider for the timer: asserts en once every presc+1 clocks.
// Clears on clr, freezes while hold is high. Used only under TIMER_PRESCALE_EN.
module tick_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               hold,
  input  logic [PRESC_W-1:0] presc,
  output logic               en
);

  logic [PRESC_W-1:0] cnt;

  // >= rather than == so a lowered presc mid-run cannot make cnt run past it
  assign en = !hold && (cnt >= presc);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      if (en) cnt <= '0;
      else    cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Start/stop/pause sequencer around a wrap counter with programmable terminal
// count and one-shot/auto-reload modes. Optional prescaler: TIMER_PRESCALE_EN.
//
//  state | meaning
//  IDLE  | stopped, count=0
//  RUN   | counting on each enable
//  HOLD  | paused, count and prescaler frozen
//  DONE  | one-shot finished, count=0, done=1
module counter_timer_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  tmr_state_e       state, state_d;
  logic [WIDTH-1:0] count_d, period_q, period_d;
  logic             mode_q, mode_d, tick_d;
  logic             active, start_go, en;

  assign active   = (state == RUN) || (state == HOLD);
  assign start_go = start && (period != '0);

`ifdef TIMER_PRESCALE_EN
  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (stop || start_go || !active),
    .hold  (active && pause),
    .presc (presc),
    .en    (en)
  );
`else
  logic unused_presc;
  assign unused_presc = ^presc;
  assign en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      tick     <= 1'b0;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else begin
      state    <= state_d;
      count    <= count_d;
      tick     <= tick_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d  = state;
    count_d  = count;
    tick_d   = 1'b0;
    period_d = period_q;
    mode_d   = mode_q;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start_go) begin
      // restart drops any tick that would have fired this cycle
      state_d  = RUN;
      count_d  = '0;
      period_d = period;
      mode_d   = mode;
    end else if (active) begin
      if (pause) begin
        state_d = HOLD;
      end else begin
        state_d = RUN;
        if (en) begin
          if (count == period_q) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (mode_q == MODE_RELOAD) period_d = period;
            else                       state_d  = DONE;
          end else begin
            count_d = count + 1'b1;
          end
        end
      end
    end
  end

  assign busy = active;
  assign done = (state == DONE);

endmodule
